// File: rtl/tc_pkg.sv
// Shared types and constants for the two's complement to sign-magnitude serial converter.
package tc_pkg;

  localparam int TC_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } tc_state_e;

endpackage

// File: rtl/tc_serial_cell.sv
// One-bit serial negation cell: bits are copied until the first 1 is seen, then inverted.
module tc_serial_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic sign,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_one_r;

  // Copy/invert rule applied to the current bit
  always_comb begin
    bit_out = bit_in;
    if (sign && seen_one_r) begin
      bit_out = ~bit_in;
    end else begin
      bit_out = bit_in;
    end
  end

  // Remembers whether a 1 has already passed through this word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_r <= 1'b0;
    end else if (clear) begin
      seen_one_r <= 1'b0;
    end else if (enable) begin
      seen_one_r <= seen_one_r | bit_in;
    end
  end

endmodule

// File: rtl/twos_to_sm_serial.sv
// Serial two's complement to sign-magnitude converter, one bit per cycle, LSB first.
// Optional out_ovf port (most-negative input flag) is enabled by defining TC_OVF_FLAG_EN.
module twos_to_sm_serial
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-2:0] out_mag
`ifdef TC_OVF_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

  tc_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-2:0] data_r;
  logic [WIDTH-2:0] mag_r;
  logic             sign_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             bit_s;
  logic [WIDTH-1:0] mag_cat_s;
`ifdef TC_OVF_FLAG_EN
  logic             lower_zero_r;
  logic             ovf_r;
`endif

  assign accept_s  = in_valid & in_ready_r & (state_r == IDLE);
  assign mag_cat_s = {bit_s, mag_r};

  tc_serial_cell u_cell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_s),
    .enable  (state_r == CONV),
    .sign    (sign_r),
    .bit_in  (data_r[0]),
    .bit_out (bit_s)
  );

  // Control FSM, bit counter and shift registers; all outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      data_r       <= '0;
      mag_r        <= '0;
      sign_r       <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
`ifdef TC_OVF_FLAG_EN
      lower_zero_r <= 1'b0;
      ovf_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r     <= in_data[WIDTH-2:0];
            sign_r     <= in_data[WIDTH-1];
            cnt_r      <= '0;
            mag_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= CONV;
`ifdef TC_OVF_FLAG_EN
            lower_zero_r <= (in_data[WIDTH-2:0] == '0);
`endif
          end
        end
        CONV: begin
          // Result bits enter at the top so the LSB lands in bit 0 after WIDTH-1 shifts
          mag_r  <= mag_cat_s[WIDTH-1:1];
          data_r <= data_r >> 1;
          if (cnt_r == CNT_LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
`ifdef TC_OVF_FLAG_EN
            ovf_r       <= sign_r & lower_zero_r;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
`ifdef TC_OVF_FLAG_EN
            ovf_r       <= 1'b0;
`endif
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sign  = sign_r;
  assign out_mag   = mag_r;
`ifdef TC_OVF_FLAG_EN
  assign out_ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_twos_to_sm_serial.sv
// Self-checking bench for twos_to_sm_serial (WIDTH=4); out_ovf checks follow TC_OVF_FLAG_EN.
module tb_twos_to_sm_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_sign;
  logic [W-2:0] out_mag;
`ifdef TC_OVF_FLAG_EN
  logic         out_ovf;
`endif

  int errors = 0;
  int checks = 0;

  twos_to_sm_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
`ifdef TC_OVF_FLAG_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: |value| truncated to W-1 bits
  function automatic logic [W-2:0] ref_mag(input logic [W-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    return v[W-2:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x);
    return int'($signed(x)) == -(1 << (W - 1));
  endfunction

  // Cycle-level model: phase 0 = accepting, 1..W-1 = converting, W = presenting
  int           m_phase = 0;
  logic [W-1:0] m_word = '0;
  int           cyc = 0;
  int           acc_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_phase == 0) begin
        if (in_valid) begin
          m_word  <= in_data;
          m_phase <= 1;
          acc_q.push_back(cyc);
        end
      end else if (m_phase < W) begin
        m_phase <= m_phase + 1;
      end else if (out_ready) begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == 0);
    check("out_valid", out_valid, m_phase == W);
    if (m_phase == W) begin
      check("out_sign", out_sign, m_word[W-1]);
      check("out_mag", out_mag, ref_mag(m_word));
    end
`ifdef TC_OVF_FLAG_EN
    check("out_ovf", out_ovf, (m_phase == W) && ref_ovf(m_word));
`endif
  end

  // Called one step after the accepting edge
  task automatic wait_result(input logic es, input logic [W-2:0] em, input logic eo, input int hold);
    int edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, W - 1);
    check("lit_sign", out_sign, es);
    check("lit_mag", out_mag, em);
`ifdef TC_OVF_FLAG_EN
    check("lit_ovf", out_ovf, eo);
`else
    if (eo) checks = checks + 0;
`endif
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check("held_valid", out_valid, 1'b1);
    check("held_mag", out_mag, em);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready", in_ready, 1'b1);
    check("idle_valid", out_valid, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] d, input logic es, input logic [W-2:0] em,
                      input logic eo, input int hold);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    wait_result(es, em, eo, hold);
  endtask

  logic [W-1:0] b2b[4] = '{4'b0111, 4'b1001, 4'b0000, 4'b1100};

  initial begin
    #12;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sign", out_sign, 1'b0);
    check("rst_mag", out_mag, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    send(4'b0101, 1'b0, 3'b101, 1'b0, 0);
    send(4'b1011, 1'b1, 3'b101, 1'b0, 0);
    send(4'b1111, 1'b1, 3'b001, 1'b0, 0);
    send(4'b1000, 1'b1, 3'b000, 1'b1, 0);
    send(4'b0000, 1'b0, 3'b000, 1'b0, 0);
    send(4'b1110, 1'b1, 3'b010, 1'b0, 5);

    // Abort on the second conversion cycle
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 4'b0110;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("first_edge_accept", in_ready, 1'b0);
    wait_result(1'b0, 3'b011, 1'b0, 0);

    // Back-to-back words with the consumer always ready
    acc_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g = 0;
      in_data  = b2b[i];
      in_valid = 1'b1;
      do begin
        @(posedge clk); #1;
        g++;
      end while (m_phase != 1 && g < 20);
      check("b2b_accept", g < 20, 1'b1);
    end
    in_valid = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_count", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b_period", acc_q[i] - acc_q[i-1], W + 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
